heartbeat_monitor: RTL and testbench

Receive-side checker for the LED heartbeat toggle signal. It detects edges on an asynchronous square-wave input and measures the interval between successive edges. It declares the source alive once the half-period stays inside a tolerance window, and flags loss of heartbeat on timeout or an out-of-window edge. It sits on the fabric side of a board-to-board or FPGA-to-MCU link, as a liveness monitor for a remote heartbeat generator.

---
 rtl/heartbeat_monitor.sv | 162 ++++++++++++++++
 tb/tb_heartbeat_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_monitor.sv
// Liveness monitor for a remote square-wave heartbeat: measures edge-to-edge intervals and tracks lock.
// Optional glitch filter on the synchronized input: define HEARTBEAT_MON_GLITCH_FILTER_EN.
module heartbeat_monitor #(
  parameter logic [31:0] HALF_PERIOD   = 32'd10000001,
  parameter logic [31:0] TOL_CYCLES    = 32'd100000,
  parameter logic [3:0]  LOCK_COUNT    = 4'd2,
  parameter logic [7:0]  FILTER_CYCLES = 8'd4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        pulse_in,
  output logic        edge_out,
  output logic        alive_out,
  output logic        lost_out,
  output logic [31:0] period_out,
  output logic [15:0] fault_count_out,
  output logic [1:0]  state_out
);

  localparam logic [31:0] MIN_INT     = HALF_PERIOD - TOL_CYCLES;
  localparam logic [31:0] MAX_INT     = HALF_PERIOD + TOL_CYCLES;
  localparam logic [31:0] TIMEOUT_INT = MAX_INT + 32'd1;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_LOCKED  = 2'b01,
    ST_LOST    = 2'b10
  } state_t;

  logic        sync1_q, sync2_q, level_q, accepted, edge_det;
  logic [31:0] cnt_q;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        timing_q, timing_d;
  state_t      state_q, state_d;
  logic        measured, good_int, bad_int, timeout;
  logic        alive_q, lost_q;
  logic [31:0] period_q;
  logic [15:0] fault_cnt_q;

`ifdef HEARTBEAT_MON_GLITCH_FILTER_EN
  logic       filt_level_q;
  logic [7:0] filt_cnt_q;

  // A new level must persist FILTER_CYCLES cycles; any return to the accepted level restarts.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      filt_level_q <= 1'b0;
      filt_cnt_q   <= 8'd0;
    end else if (sync2_q == filt_level_q) begin
      filt_cnt_q <= 8'd0;
    end else if (filt_cnt_q + 8'd1 == FILTER_CYCLES) begin
      filt_level_q <= sync2_q;
      filt_cnt_q   <= 8'd0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 8'd1;
    end
  end

  assign accepted = filt_level_q;
`else
  logic unused_filter;
  assign unused_filter = ^FILTER_CYCLES;
  assign accepted      = sync2_q;
`endif

  assign edge_det = accepted ^ level_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      edge_out <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      sync1_q  <= pulse_in;
      sync2_q  <= sync1_q;
      level_q  <= accepted;
      edge_out <= edge_det;
      if (edge_det)
        cnt_q <= 32'd1;
      else if (cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  // cnt_q still holds the pre-load value on the edge cycle, so it is the interval itself.
  assign measured = edge_det & timing_q;
  assign good_int = measured && (cnt_q >= MIN_INT) && (cnt_q <= MAX_INT);
  assign bad_int  = measured && !good_int;
  assign timeout  = timing_q && !edge_det && (cnt_q == TIMEOUT_INT);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    timing_d   = timing_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (edge_det && !timing_q) begin
          timing_d = 1'b1;
        end else if (bad_int) begin
          good_cnt_d = 4'd0;
        end else if (timeout) begin
          good_cnt_d = 4'd0;
          timing_d   = 1'b0;
        end else if (good_cnt_q == LOCK_COUNT) begin
          state_d    = ST_LOCKED;
          good_cnt_d = 4'd0;
        end else if (good_int) begin
          good_cnt_d = good_cnt_q + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (bad_int || timeout) begin
          state_d  = ST_LOST;
          timing_d = 1'b0;
        end
      end
      ST_LOST: begin
        if (edge_det) begin
          state_d    = ST_ACQUIRE;
          timing_d   = 1'b1;
          good_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = ST_ACQUIRE;
        good_cnt_d = 4'd0;
        timing_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_ACQUIRE;
      good_cnt_q  <= 4'd0;
      timing_q    <= 1'b0;
      alive_q     <= 1'b0;
      lost_q      <= 1'b0;
      period_q    <= 32'd0;
      fault_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      timing_q   <= timing_d;
      alive_q    <= (state_d == ST_LOCKED);
      lost_q     <= (state_q == ST_LOCKED) && (state_d == ST_LOST);
      if (measured)
        period_q <= cnt_q;
      if ((state_q == ST_LOCKED) && (state_d == ST_LOST) && (fault_cnt_q != 16'hFFFF))
        fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

  assign alive_out       = alive_q;
  assign lost_out        = lost_q;
  assign period_out      = period_q;
  assign fault_count_out = fault_cnt_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor with a short heartbeat (100 +/- 10 cycles).
module tb_heartbeat_monitor;

`ifdef HEARTBEAT_MON_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_in;
  logic        pulse_in;
  logic        edge_out, alive_out, lost_out;
  logic [31:0] period_out;
  logic [15:0] fault_count_out;
  logic [1:0]  state_out;

  int          cyc = 0;
  int          since = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  heartbeat_monitor #(
    .HALF_PERIOD  (32'd100),
    .TOL_CYCLES   (32'd10),
    .LOCK_COUNT   (4'd2),
    .FILTER_CYCLES(8'd4)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .pulse_in       (pulse_in),
    .edge_out       (edge_out),
    .alive_out      (alive_out),
    .lost_out       (lost_out),
    .period_out     (period_out),
    .fault_count_out(fault_count_out),
    .state_out      (state_out)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_all(input logic e, input logic a, input logic l,
                           input logic [31:0] p, input logic [15:0] f, input logic [1:0] s);
    check("edge_out", {31'd0, edge_out}, {31'd0, e});
    check("alive_out", {31'd0, alive_out}, {31'd0, a});
    check("lost_out", {31'd0, lost_out}, {31'd0, l});
    check("period_out", period_out, p);
    check("fault_count", {16'd0, fault_count_out}, {16'd0, f});
    check("state_out", {30'd0, state_out}, {30'd0, s});
  endtask

  task automatic check_state(input logic [1:0] s, input logic a);
    check("state_out", {30'd0, state_out}, {30'd0, s});
    check("alive_out", {31'd0, alive_out}, {31'd0, a});
  endtask

  // drivers
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    since += n;
  endtask

  // Toggle pulse_in n cycles after the previous toggle; exp is period_out at the resulting edge.
  task automatic toggle_at(input int n, input logic [31:0] exp);
    if (n > since) wait_n(n - since);
    pulse_in = ~pulse_in;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1 + LAT);
    since = 0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    pulse_in = 1'b0;
    wait_n(1);
    reset_in = 1'b0;
    check_all(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 2'b00);
    since = 0;
  endtask

  task automatic relock(input int first_gap, input logic [31:0] prev_period);
    toggle_at(first_gap, prev_period);
    toggle_at(100, 32'd100);
    toggle_at(100, 32'd100);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);
  endtask

  // scoreboard: every edge_out must match the head of the expected queues
  always @(negedge clk) begin
    if (!reset_in) begin
      if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        check("edge_missed", 32'(cyc), 32'(exp_cyc_q[0]));
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end else if (edge_out) begin
        if (exp_cyc_q.size() == 0) begin
          check("edge_unexpected", {31'd0, edge_out}, 32'd0);
        end else begin
          check("edge_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
          check("edge_period", period_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_in = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    check_all(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 2'b00);
    since = 0;

    // lock from reset: first edge unmeasured, then two good intervals
    toggle_at(5, 32'd0);
    toggle_at(100, 32'd100);
    toggle_at(100, 32'd100);
    wait_n(LAT + 1);
    check_state(2'b00, 1'b0);
    wait_n(1);
    check_state(2'b01, 1'b1);

    // window boundaries while locked
    toggle_at(100, 32'd100);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);
    toggle_at(89, 32'd89);
    wait_n(LAT + 1);
    check_all(1'b1, 1'b0, 1'b1, 32'd89, 16'd1, 2'b10);
    wait_n(1);
    check("lost_pulse_end", {31'd0, lost_out}, 32'd0);
    relock(20, 32'd89);
    toggle_at(90, 32'd90);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);
    toggle_at(110, 32'd110);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);
    // edge lands on the timeout cycle: one loss, one fault
    toggle_at(111, 32'd111);
    wait_n(LAT + 1);
    check_all(1'b1, 1'b0, 1'b1, 32'd111, 16'd2, 2'b10);
    wait_n(3);
    check("fault_once", {16'd0, fault_count_out}, 32'd2);
    check("lost_once", {31'd0, lost_out}, 32'd0);

    // timeout while locked
    relock(20, 32'd111);
    wait_n(LAT + 111 - since);
    check("pre_timeout_lost", {31'd0, lost_out}, 32'd0);
    check("pre_timeout_state", {30'd0, state_out}, 32'd1);
    wait_n(1);
    check_all(1'b0, 1'b0, 1'b1, 32'd100, 16'd3, 2'b10);
    wait_n(1);
    check("lost_pulse_end", {31'd0, lost_out}, 32'd0);
    toggle_at(since + 10, 32'd100);
    wait_n(LAT + 1);
    check_state(2'b00, 1'b0);
    toggle_at(100, 32'd100);
    toggle_at(100, 32'd100);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);

    // fault counter saturation
    force dut.fault_cnt_q = 16'hFFFE;
    wait_n(1);
    release dut.fault_cnt_q;
    wait_n(1);
    check("fault_preset", {16'd0, fault_count_out}, 32'hFFFE);
    toggle_at(89, 32'd89);
    wait_n(LAT + 1);
    check("fault_to_max", {16'd0, fault_count_out}, 32'hFFFF);
    relock(20, 32'd89);
    toggle_at(89, 32'd89);
    wait_n(LAT + 1);
    check("lost_at_max", {31'd0, lost_out}, 32'd1);
    check("fault_saturated", {16'd0, fault_count_out}, 32'hFFFF);

    // reset mid-interval, then acquisition with timeout and bad-interval restart
    relock(20, 32'd89);
    wait_n(50 - since);
    do_reset();
    toggle_at(60, 32'd0);
    toggle_at(200, 32'd0);
    wait_n(LAT + 1);
    check_state(2'b00, 1'b0);
    toggle_at(100, 32'd100);
    toggle_at(50, 32'd50);
    toggle_at(100, 32'd100);
    wait_n(LAT + 2);
    check_state(2'b00, 1'b0);
    toggle_at(100, 32'd100);
    wait_n(LAT + 2);
    check_state(2'b01, 1'b1);

`ifdef HEARTBEAT_MON_GLITCH_FILTER_EN
    // a 3-cycle glitch is swallowed; a held change appears after sync + filter
    do_reset();
    wait_n(5);
    pulse_in = 1'b1;
    wait_n(3);
    pulse_in = 1'b0;
    wait_n(20);
    check_all(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 2'b00);
    toggle_at(0, 32'd0);
    wait_n(LAT + 1);
    check("filtered_edge", {31'd0, edge_out}, 32'd1);
`endif

    wait_n(LAT + 3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
